// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out controller:
// state encoding and bit-count width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Wide enough to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift datapath; zero-fills from the far end on each shift.
// Pure datapath: load has priority over shift_en, reset clears everything.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_bit
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
      else           sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign ser_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_shift_ctrl.sv
// Sequences one parallel word out as WIDTH serial beats with backpressure,
// then pulses done for one cycle before accepting the next word.
module piso_shift_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic          ser_valid_q;
  logic          done_q;
  logic          load;
  logic          beat;

  assign load = (state_q == ST_IDLE) && in_valid;
  assign beat = (state_q == ST_SHIFT) && ser_valid_q && ser_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (in_valid) begin
            state_q     <= ST_SHIFT;
            count_q     <= CNT_FULL;
            ser_valid_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            count_q <= count_q - CW'(1);
            if (count_q == CNT_LAST) begin
              state_q     <= ST_DONE;
              ser_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          count_q     <= '0;
          ser_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // Zero-fill guarantees the register is empty once the last bit leaves,
  // so ser_out reads 0 in IDLE and DONE without extra gating.
  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift_en  (beat),
    .load_data (in_data),
    .ser_bit   (ser_out)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share stimulus;
// a word-level reference model predicts bits and handshake state.
module tb_piso_shift_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         ser_ready;

  logic in_ready_m, ser_out_m, ser_valid_m, done_m, busy_m;
  logic in_ready_l, ser_out_l, ser_valid_l, done_l, busy_l;

  int checks = 0;
  int errors = 0;

  logic bit_q_m[$];
  logic bit_q_l[$];
  int   m_phase = 0;
  int   m_left  = 0;
  logic [W-1:0] obs_m = '0;
  logic [W-1:0] obs_l = '0;

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_data   (in_data),
    .ser_out   (ser_out_m),
    .ser_valid (ser_valid_m),
    .ser_ready (ser_ready),
    .done      (done_m),
    .busy      (busy_m)
  );

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .in_data   (in_data),
    .ser_out   (ser_out_l),
    .ser_valid (ser_valid_l),
    .ser_ready (ser_ready),
    .done      (done_l),
    .busy      (busy_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Reference model: phase 0 = idle, 1 = shifting, 2 = done cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      bit_q_m.delete();
      bit_q_l.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase = 1;
          m_left  = W;
          for (int i = W - 1; i >= 0; i--) bit_q_m.push_back(in_data[i]);
          for (int i = 0; i < W; i++)      bit_q_l.push_back(in_data[i]);
        end
        1: if (ser_ready) begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor: compare control outputs every cycle, pop the scoreboard on beats.
  always @(negedge clk) begin
    logic b;
    chk("in_ready_m",  in_ready_m,  m_phase == 0);
    chk("in_ready_l",  in_ready_l,  m_phase == 0);
    chk("busy_m",      busy_m,      m_phase != 0);
    chk("busy_l",      busy_l,      m_phase != 0);
    chk("done_m",      done_m,      m_phase == 2);
    chk("done_l",      done_l,      m_phase == 2);
    chk("ser_valid_m", ser_valid_m, m_phase == 1);
    chk("ser_valid_l", ser_valid_l, m_phase == 1);
    if (m_phase != 1) begin
      chk("ser_out_idle_m", ser_out_m, 0);
      chk("ser_out_idle_l", ser_out_l, 0);
    end
    if (ser_valid_m && ser_ready && !reset) begin
      if (bit_q_m.size() == 0) chk("sb_underflow_m", bit_q_m.size(), 1);
      else begin
        b = bit_q_m.pop_front();
        chk("bit_m", ser_out_m, b);
        obs_m = {obs_m[W-2:0], ser_out_m};
      end
    end
    if (ser_valid_l && ser_ready && !reset) begin
      if (bit_q_l.size() == 0) chk("sb_underflow_l", bit_q_l.size(), 1);
      else begin
        b = bit_q_l.pop_front();
        chk("bit_l", ser_out_l, b);
        obs_l = {obs_l[W-2:0], ser_out_l};
      end
    end
  end

  task automatic cyc(input logic r, input logic iv, input logic [W-1:0] d, input logic sr);
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic check_word(input string name, input logic [W-1:0] word);
    chk({name, "_msb"}, obs_m, word);
    chk({name, "_lsb"}, obs_l, rev(word));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; ser_ready = 1'b1;

    // reset held with a pending load request
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // basic word, no backpressure
    obs_m = '0; obs_l = '0;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(10);
    check_word("basic", 8'hA5);

    // backpressure after the second beat
    obs_m = '0; obs_l = '0;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    idle(8);
    check_word("bpress", 8'hA5);

    // load attempts while shifting are ignored
    obs_m = '0; obs_l = '0;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    idle(6);
    check_word("busyload", 8'hA5);

    // reset after four beats, coinciding with a fifth beat
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(4);
    cyc(1'b1, 1'b0, '0, 1'b1);
    obs_m = '0; obs_l = '0;
    cyc(1'b0, 1'b1, 8'h3C, 1'b1);
    idle(10);
    check_word("postrst", 8'h3C);

    // single set bit shows bit order
    obs_m = '0; obs_l = '0;
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    idle(10);
    check_word("order", 8'h01);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 2,
          1'($urandom_range(0, 1)),
          W'($urandom),
          $urandom_range(0, 99) < 70);
    end

    idle(W + 4);
    chk("sb_drain_m", bit_q_m.size(), 0);
    chk("sb_drain_l", bit_q_l.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
